// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte image and writes
// little-endian 32-bit words into instruction memory, releasing the CPU when verified.
module imem_boot_loader #(
  parameter int DEPTH = 64,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             imem_we,
  output logic [31:0]      imem_addr,
  output logic [31:0]      imem_wdata,
  output logic             cpu_rst,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] word_cnt,
  output logic [2:0]       state_dbg
);

  // Handshake: a byte moves on a rising edge where in_valid && in_ready; in_ready
  // is registered and depends only on state, never on in_valid.
  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_LOAD, S_WRITE, S_CSUM, S_DONE, S_ERROR
  } state_t;

  localparam logic [7:0]       HDR_MAX = 8'(DEPTH);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state, state_d;
  logic [1:0]       byte_cnt, byte_cnt_d;
  logic [CNT_W-1:0] word_idx, word_idx_d, hdr_n, hdr_n_d, word_cnt_d;
  logic [7:0]       csum, csum_d;
  logic [23:0]      word_buf, word_buf_d;
  logic [31:0]      imem_addr_d, imem_wdata_d;
  logic             in_ready_d, imem_we_d, cpu_rst_d, busy_d, done_d, err_d;
  logic             xfer;

  assign xfer      = in_valid & in_ready;
  assign state_dbg = state;

  always_comb begin
    state_d      = state;
    byte_cnt_d   = byte_cnt;
    word_idx_d   = word_idx;
    hdr_n_d      = hdr_n;
    csum_d       = csum;
    word_buf_d   = word_buf;
    imem_addr_d  = imem_addr;
    imem_wdata_d = imem_wdata;
    word_cnt_d   = word_cnt;
    in_ready_d   = 1'b0;
    imem_we_d    = 1'b0;
    cpu_rst_d    = cpu_rst;
    busy_d       = busy;
    done_d       = done;
    err_d        = err;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_d    = S_HDR;
          in_ready_d = 1'b1;
          busy_d     = 1'b1;
        end
      end
      S_HDR: begin
        in_ready_d = 1'b1;
        if (xfer) begin
          if (in_data == 8'd0 || in_data > HDR_MAX) begin
            state_d    = S_ERROR;
            in_ready_d = 1'b0;
            busy_d     = 1'b0;
            err_d      = 1'b1;
          end else begin
            state_d    = S_LOAD;
            hdr_n_d    = CNT_W'(in_data);
            csum_d     = 8'd0;
            byte_cnt_d = 2'd0;
          end
        end
      end
      S_LOAD: begin
        in_ready_d = 1'b1;
        if (xfer) begin
          csum_d     = csum ^ in_data;
          byte_cnt_d = byte_cnt + 2'd1;
          case (byte_cnt)
            2'd0: word_buf_d[7:0]   = in_data;
            2'd1: word_buf_d[15:8]  = in_data;
            2'd2: word_buf_d[23:16] = in_data;
            default: begin
              // Fourth byte goes straight into the write data register.
              state_d      = S_WRITE;
              in_ready_d   = 1'b0;
              imem_we_d    = 1'b1;
              imem_addr_d  = 32'(word_idx) << 2;
              imem_wdata_d = {in_data, word_buf};
            end
          endcase
        end
      end
      S_WRITE: begin
        in_ready_d = 1'b1;
        word_cnt_d = word_cnt + ONE;
        if (word_idx + ONE == hdr_n) begin
          state_d = S_CSUM;
        end else begin
          state_d    = S_LOAD;
          word_idx_d = word_idx + ONE;
        end
      end
      S_CSUM: begin
        in_ready_d = 1'b1;
        if (xfer) begin
          in_ready_d = 1'b0;
          busy_d     = 1'b0;
          if (in_data == csum) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            cpu_rst_d = 1'b1;
          end else begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end
        end
      end
      S_DONE, S_ERROR: begin
        if (start) begin
          state_d    = S_HDR;
          in_ready_d = 1'b1;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          err_d      = 1'b0;
          cpu_rst_d  = 1'b0;
          word_cnt_d = '0;
          word_idx_d = '0;
          byte_cnt_d = 2'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      byte_cnt   <= 2'd0;
      word_idx   <= '0;
      hdr_n      <= '0;
      csum       <= 8'd0;
      word_buf   <= 24'd0;
      imem_addr  <= 32'd0;
      imem_wdata <= 32'd0;
      word_cnt   <= '0;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      cpu_rst    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_d;
      byte_cnt   <= byte_cnt_d;
      word_idx   <= word_idx_d;
      hdr_n      <= hdr_n_d;
      csum       <= csum_d;
      word_buf   <= word_buf_d;
      imem_addr  <= imem_addr_d;
      imem_wdata <= imem_wdata_d;
      word_cnt   <= word_cnt_d;
      in_ready   <= in_ready_d;
      imem_we    <= imem_we_d;
      cpu_rst    <= cpu_rst_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: table of load cases plus random loads, checked
// against a byte-level image model and a write scoreboard.
module tb_imem_boot_loader;

  localparam int DEPTH = 64;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_data = 8'd0;
  logic             in_ready, imem_we, cpu_rst, busy, done, err;
  logic [31:0]      imem_addr, imem_wdata;
  logic [CNT_W-1:0] word_cnt;
  logic [2:0]       state_dbg;

  imem_boot_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_rst(cpu_rst), .busy(busy), .done(done),
    .err(err), .word_cnt(word_cnt), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] hdr;
    bit         fixed;
    logic [7:0] corrupt;
    bit         gaps;
    bit         exp_done;
    bit         exp_err;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t        tbl[10];
  logic [7:0]  good_pl[8];
  logic [63:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Write scoreboard: every imem_we cycle must match the next expected {addr, data}.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) check("spurious_we", {imem_addr, imem_wdata}, 64'hdead);
      else check("imem_write", {imem_addr, imem_wdata}, exp_q.pop_front());
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps, input bit word_end);
    int cyc = 0;
    bit took = 0;
    if (gaps) begin
      while ($urandom_range(0, 2) == 0 && cyc < 4) begin
        in_valid = 1'b0;
        start = ($urandom_range(0, 5) == 0);
        step();
        cyc++;
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!took && cyc < 200) begin
      start = gaps ? ($urandom_range(0, 7) == 0) : 1'b0;
      if (imem_we) check("ready_in_write", 64'(in_ready), 64'd0);
      took = in_ready;
      step();
      cyc++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check("byte_accepted", 64'(took), 64'd1);
    if (word_end) check("we_latency", 64'(imem_we), 64'd1);
  endtask

  // Model: builds the image, queues the expected writes, streams it, checks the outcome.
  task automatic run_vec(input vec_t v, input string tag);
    logic [7:0] q[$];
    logic [7:0] cs = 8'd0;
    logic [7:0] b;
    bit hdr_ok;
    int n;
    hdr_ok = (v.hdr != 0) && (int'(v.hdr) <= DEPTH);
    n = hdr_ok ? int'(v.hdr) : 0;
    q.push_back(v.hdr);
    for (int i = 0; i < 4 * n; i++) begin
      b = v.fixed ? good_pl[i % 8] : 8'($urandom_range(0, 255));
      q.push_back(b);
      cs ^= b;
    end
    if (hdr_ok) q.push_back(cs ^ v.corrupt);
    for (int w = 0; w < n; w++)
      exp_q.push_back({32'(w * 4), q[4*w+4], q[4*w+3], q[4*w+2], q[4*w+1]});

    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_start_flags"}, {59'd0, busy, in_ready, done, err, cpu_rst}, 64'b11000);
    check({tag, "_start_cnt"}, 64'(word_cnt), 64'd0);
    for (int i = 0; i < q.size(); i++)
      send_byte(q[i], v.gaps, hdr_ok && i >= 4 && i <= 4 * n && (i % 4) == 0);
    check({tag, "_done"}, 64'(done), 64'(v.exp_done));
    check({tag, "_err"}, 64'(err), 64'(v.exp_err));
    check({tag, "_cpu_rst"}, 64'(cpu_rst), 64'(v.exp_done));
    check({tag, "_busy_ready"}, {62'd0, busy, in_ready}, 64'd0);
    check({tag, "_word_cnt"}, 64'(word_cnt), 64'(v.exp_cnt));
    check({tag, "_writes_seen"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    vec_t rv;
    logic [7:0] h;
    good_pl = '{8'h13, 8'h00, 8'h08, 8'h20, 8'h78, 8'h56, 8'h34, 8'h12};
    //          hdr    fix cor    gap done err cnt
    tbl[0] = '{8'd2,   1, 8'h00, 0, 1, 0, 8'd2};
    tbl[1] = '{8'd2,   1, 8'h07, 0, 0, 1, 8'd2};
    tbl[2] = '{8'd0,   0, 8'h00, 0, 0, 1, 8'd0};
    tbl[3] = '{8'd65,  0, 8'h00, 0, 0, 1, 8'd0};
    tbl[4] = '{8'd2,   1, 8'h00, 1, 1, 0, 8'd2};
    tbl[5] = '{8'd1,   0, 8'h00, 1, 1, 0, 8'd1};
    tbl[6] = '{8'd64,  0, 8'h00, 0, 1, 0, 8'd64};
    tbl[7] = '{8'd5,   0, 8'h80, 1, 0, 1, 8'd5};
    tbl[8] = '{8'd255, 0, 8'h00, 1, 0, 1, 8'd0};
    tbl[9] = '{8'd3,   0, 8'h00, 1, 1, 0, 8'd3};

    // Reset held with start and in_valid asserted.
    rst = 1'b0; start = 1'b1; in_valid = 1'b1; in_data = 8'h02;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_flags", {57'd0, in_ready, imem_we, cpu_rst, busy, done, err, 1'b0}, 64'd0);
      check("rst_addr_data", {imem_addr, imem_wdata}, 64'd0);
      check("rst_cnt", 64'(word_cnt), 64'd0);
    end
    start = 1'b0; in_valid = 1'b0;
    rst = 1'b1;
    step();
    check("idle_ready", {62'd0, in_ready, busy}, 64'd0);

    for (int i = 0; i < 10; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

    // Reset after five payload bytes, then a fresh good load.
    start = 1'b1;
    step();
    start = 1'b0;
    exp_q.push_back({32'd0, 32'h20080013});
    send_byte(8'd2, 0, 0);
    for (int i = 0; i < 5; i++) send_byte(good_pl[i], 0, i == 3);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("midrst_flags", {57'd0, in_ready, imem_we, cpu_rst, busy, done, err, 1'b0}, 64'd0);
    check("midrst_cnt", 64'(word_cnt), 64'd0);
    check("midrst_writes", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    step();
    check("midrst_idle", 64'(state_dbg), 64'd0);
    run_vec(tbl[0], "after_rst");

    // Random loads; outcome follows from header range and checksum corruption.
    for (int k = 0; k < 8; k++) begin
      h = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(1, 12));
      rv.hdr     = h;
      rv.fixed   = 0;
      rv.corrupt = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      rv.gaps    = $urandom_range(0, 1);
      rv.exp_cnt = (h != 0 && int'(h) <= DEPTH) ? h : 8'd0;
      rv.exp_done = (rv.exp_cnt != 0) && (rv.corrupt == 8'h00);
      rv.exp_err  = !rv.exp_done;
      run_vec(rv, $sformatf("rnd%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
Boot-time instruction loader that sits directly upstream of the processor top level. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. It writes those words into the instruction memory write port and holds the CPU in reset until a complete, checksum-verified image has been loaded. On success it releases the CPU so execution starts at PC 0.

Parameters:
DEPTH, 64, instruction memory capacity in 32-bit words; legal word counts are 1..DEPTH (DEPTH <= 255)
CNT_W, 8, width of the word index and word counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-low (0 = reset)
start  input  1  single-cycle request to begin or restart a load
in_valid  input  1  in_data holds a valid byte
in_data  input  8  stream byte
in_ready  output  1  loader accepts a byte this cycle
imem_we  output  1  instruction memory write enable, one cycle per word
imem_addr  output  32  byte address, word aligned (index<<2)
imem_wdata  output  32  assembled instruction word
cpu_rst  output  1  CPU reset, active-low; 0 holds the CPU in reset
busy  output  1  load in progress
done  output  1  image loaded and verified
err  output  1  load aborted (bad header or checksum)
word_cnt  output  CNT_W  number of words written so far

Behaviour:
- All outputs are registered. A byte transfers on a clock edge where in_valid=1 and in_ready=1.
- Reset (rst=0 at an edge), regardless of state:
  - State goes to IDLE.
  - in_ready, imem_we, imem_addr, imem_wdata, cpu_rst, busy, done, err and word_cnt all go to 0.
  - Internal byte counter, word index, header register and checksum register clear.
  - A reset mid-load abandons the load; memory contents already written are left as-is.
- IDLE: in_ready=0, cpu_rst=0. When start=1, go to HDR with busy=1.
- HDR: in_ready=1. The first transferred byte is N, the word count.
  - N=0 or N>DEPTH: go to ERROR.
  - Otherwise store N, clear the checksum, and go to LOAD.
- LOAD: in_ready=1. Bytes are placed little-endian: the 1st byte goes to [7:0], the 2nd to [15:8], the 3rd to [23:16], the 4th to [31:24].
  - Each payload byte is XORed into the 8-bit checksum.
  - On the 4th byte's transfer, go to WRITE.
- WRITE (exactly 1 cycle): in_ready=0, imem_we=1, imem_addr=index<<2, imem_wdata=assembled word.
  - imem_we rises on the cycle after the 4th byte transfer, giving 1-cycle latency.
  - word_cnt increments on the same edge that ends WRITE.
  - If index+1 == N, go to CSUM; otherwise increment the index and return to LOAD.
- CSUM: in_ready=1. The next transferred byte is compared against the checksum.
  - Match: go to DONE.
  - Mismatch: go to ERROR.
- DONE: done=1, cpu_rst=1 (CPU released), busy=0, in_ready=0.
- ERROR: err=1, cpu_rst=0, busy=0, in_ready=0.
- Stalls: in_valid low in any accepting state stalls without penalty; there is no timeout. A byte presented during WRITE is held by the source and accepted in the following LOAD cycle.
- imem_we is 0 in every state except WRITE.
- start is ignored while busy=1.
- start in DONE or ERROR restarts the load:
  - Go to HDR.
  - done, err, word_cnt and index clear.
  - cpu_rst returns to 0 on the same edge.
- start while rst=0: reset wins.
- Bytes presented while in IDLE, DONE or ERROR are not accepted (in_ready=0).

Test Plan:
- Reset: hold rst=0 for 3 cycles with in_valid=1 and start=1 -> all outputs 0, in_ready=0 throughout.
- Good load: start, then stream 02,13,00,08,20,78,56,34,12,33 back-to-back.
  - imem_we pulses: addr 0x0 with data 0x20080013, then addr 0x4 with data 0x12345678, each one cycle after the 4th byte of its word.
  - word_cnt reaches 2; done=1, cpu_rst=1, err=0.
- Bad checksum: same stream with last byte 0x34 -> two writes occur, then err=1, done=0, cpu_rst stays 0.
- Bad header: header 0x00, then a separate run with header DEPTH+1 -> err=1 on the cycle after the header transfer, no imem_we, word_cnt=0.
- Backpressure and gaps: insert random in_valid=0 gaps and present a byte during WRITE.
  - in_ready=0 in WRITE and the byte is not consumed until the following LOAD cycle.
  - Written words are identical to the good-load case.
- Reset mid-load and restart:
  - rst=0 after 5 payload bytes -> outputs return to reset values.
  - A new start with the good stream completes with done=1.
  - start while in DONE re-enters HDR with cpu_rst=0 and done=0.
